// File: rtl/dir_input_conditioner.sv
// Turns four raw, bouncing direction buttons into clean single-cycle N/S/E/W
// move pulses for the room FSM. Chords are rejected and the block locks on game over.
module dir_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       btn_s,
  input  logic       btn_e,
  input  logic       btn_w,
  input  logic       game_over,
  output logic       N,
  output logic       S,
  output logic       E,
  output logic       W,
  output logic [7:0] moves
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LOCKED
  } state_t;

  // Bit order everywhere is {n, s, e, w}.
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    d;
  logic [CW-1:0] cnt [4];

  state_t     state;
  state_t     state_nxt;
  logic [3:0] pulse;
  logic [3:0] pulse_nxt;
  logic       accept;
  logic       one_hot;
  logic       any_set;

  assign raw = {btn_n, btn_s, btn_e, btn_w};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving
      // a true two-stage chain; blocking would collapse it to one flop.
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d <= '0;
      // NOTE: the counter array is small register state, not RAM, so it is
      // cleared by the asynchronous reset like every other flop here.
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == d[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          d[i]   <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign any_set = (d != 4'd0);
  assign one_hot = any_set && ((d & (d - 4'd1)) == 4'd0);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_nxt = state;
    pulse_nxt = '0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (game_over) begin
          state_nxt = LOCKED;
        end else if (one_hot) begin
          pulse_nxt = d;
          accept    = 1'b1;
          state_nxt = HELD;
        end else if (any_set) begin
          state_nxt = HELD;
        end
      end
      HELD: begin
        if (game_over) state_nxt = LOCKED;
        else if (!any_set) state_nxt = IDLE;
      end
      LOCKED:  state_nxt = LOCKED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pulse <= '0;
      moves <= '0;
    end else begin
      state <= state_nxt;
      pulse <= pulse_nxt;
      if (accept && (moves != 8'hFF)) moves <= moves + 8'd1;
    end
  end

  assign {N, S, E, W} = pulse;

endmodule

// File: tb/tb_dir_input_conditioner.sv
// Directed bench for dir_input_conditioner with DEBOUNCE_CYCLES = 4: press latency,
// bounce, chords, sequencing, lock, asynchronous reset and move-count saturation.
module tb_dir_input_conditioner;

  localparam int DB = 4;

  logic       clk;
  logic       reset;
  logic       btn_n, btn_s, btn_e, btn_w;
  logic       game_over;
  logic       N, S, E, W;
  logic [7:0] moves;

  int n_checks;
  int n_fail;

  // Pulse monitor state, cleared per scenario.
  int         cyc;
  int         pulse_count;
  int         last_cycle;
  logic [3:0] last_dir;
  logic       multi_hot;
  logic       long_pulse;
  logic       prev_pulse;
  logic [3:0] dirs[$];

  dir_input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_n    (btn_n),
    .btn_s    (btn_s),
    .btn_e    (btn_e),
    .btn_w    (btn_w),
    .game_over(game_over),
    .N        (N),
    .S        (S),
    .E        (E),
    .W        (W),
    .moves    (moves)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_mon();
    cyc         = 0;
    pulse_count = 0;
    last_cycle  = -1;
    last_dir    = 4'd0;
    multi_hot   = 1'b0;
    long_pulse  = 1'b0;
    prev_pulse  = 1'b0;
    dirs.delete();
  endtask

  // Each cycle: one rising edge, then sample on the falling edge.
  task automatic run(input int n);
    logic [3:0] o;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      o = {N, S, E, W};
      if (o != 4'd0) begin
        pulse_count++;
        last_cycle = cyc;
        last_dir   = o;
        dirs.push_back(o);
        if (prev_pulse) long_pulse = 1'b1;
      end
      if ((o & (o - 4'd1)) != 4'd0) multi_hot = 1'b1;
      prev_pulse = (o != 4'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {btn_n, btn_s, btn_e, btn_w} = 4'd0;
    game_over = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({N, S, E, W} !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b expected 0000", {N, S, E, W});
    end
    n_checks++;
    if (moves !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_moves: got %0d expected 0", moves);
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    clear_mon();
    btn_e = 1'b1;
    run(40);
    n_checks++;
    if (pulse_count !== 1) begin
      n_fail++;
      $display("FAIL clean_count: got %0d expected 1", pulse_count);
    end
    n_checks++;
    if (last_cycle !== 7 || last_dir !== 4'b0010) begin
      n_fail++;
      $display("FAIL clean_timing: got cycle %0d dir %b expected cycle 7 dir 0010", last_cycle, last_dir);
    end
    n_checks++;
    if (moves !== 8'd1) begin
      n_fail++;
      $display("FAIL clean_moves: got %0d expected 1", moves);
    end
    btn_e = 1'b0;
    run(12);
    n_checks++;
    if (pulse_count !== 1) begin
      n_fail++;
      $display("FAIL clean_release: got %0d pulses expected 1", pulse_count);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    do_reset();
    clear_mon();
    pat = 5'b10110; // applied msb first: 1,0,1,1,0
    for (int i = 4; i >= 0; i--) begin
      btn_s = pat[i];
      run(1);
    end
    btn_s = 1'b1;
    run(30);
    n_checks++;
    if (pulse_count !== 1 || last_cycle !== 12 || last_dir !== 4'b0100) begin
      n_fail++;
      $display("FAIL bounce: got %0d pulses, cycle %0d dir %b expected 1 pulse cycle 12 dir 0100", pulse_count, last_cycle, last_dir);
    end
    n_checks++;
    if (moves !== 8'd1) begin
      n_fail++;
      $display("FAIL bounce_moves: got %0d expected 1", moves);
    end
  endtask

  task automatic test_chord();
    do_reset();
    clear_mon();
    btn_n = 1'b1;
    btn_w = 1'b1;
    run(30);
    n_checks++;
    if (pulse_count !== 0 || moves !== 8'd0) begin
      n_fail++;
      $display("FAIL chord_reject: got %0d pulses moves %0d expected 0 pulses moves 0", pulse_count, moves);
    end
    btn_n = 1'b0;
    btn_w = 1'b0;
    run(12);
    clear_mon();
    btn_w = 1'b1;
    run(20);
    n_checks++;
    if (pulse_count !== 1 || last_cycle !== 7 || last_dir !== 4'b0001) begin
      n_fail++;
      $display("FAIL chord_after: got %0d pulses cycle %0d dir %b expected 1 pulse cycle 7 dir 0001", pulse_count, last_cycle, last_dir);
    end
    n_checks++;
    if (moves !== 8'd1) begin
      n_fail++;
      $display("FAIL chord_moves: got %0d expected 1", moves);
    end
    btn_w = 1'b0;
    run(12);
  endtask

  task automatic test_sequence();
    do_reset();
    clear_mon();
    btn_e = 1'b1; run(20); btn_e = 1'b0; run(12);
    btn_s = 1'b1; run(20); btn_s = 1'b0; run(12);
    btn_w = 1'b1; run(20); btn_w = 1'b0; run(12);
    n_checks++;
    if (dirs.size() !== 3) begin
      n_fail++;
      $display("FAIL seq_count: got %0d pulses expected 3", dirs.size());
    end else begin
      n_checks++;
      if (dirs[0] !== 4'b0010 || dirs[1] !== 4'b0100 || dirs[2] !== 4'b0001) begin
        n_fail++;
        $display("FAIL seq_order: got %b %b %b expected 0010 0100 0001", dirs[0], dirs[1], dirs[2]);
      end
    end
    n_checks++;
    if (moves !== 8'd3) begin
      n_fail++;
      $display("FAIL seq_moves: got %0d expected 3", moves);
    end
    n_checks++;
    if (multi_hot !== 1'b0 || long_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_shape: got multi %b long %b expected 0 0", multi_hot, long_pulse);
    end
  endtask

  task automatic test_lock();
    do_reset();
    btn_e = 1'b1; run(20); btn_e = 1'b0; run(12);
    clear_mon();
    btn_w = 1'b1;
    run(6);          // db_w rises on the edge just taken
    game_over = 1'b1;
    run(1);
    game_over = 1'b0;
    run(30);
    n_checks++;
    if (pulse_count !== 0) begin
      n_fail++;
      $display("FAIL lock_press: got %0d pulses expected 0", pulse_count);
    end
    btn_w = 1'b0; run(12);
    btn_n = 1'b1; run(20); btn_n = 1'b0; run(12);
    n_checks++;
    if (pulse_count !== 0 || moves !== 8'd1) begin
      n_fail++;
      $display("FAIL lock_frozen: got %0d pulses moves %0d expected 0 pulses moves 1", pulse_count, moves);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_n = 1'b1; run(20); btn_n = 1'b0; run(12);
    clear_mon();
    btn_e = 1'b1;
    run(4);          // counter for e now at 2
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({N, S, E, W} !== 4'd0 || moves !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async: got pulses %b moves %0d expected 0000 and 0", {N, S, E, W}, moves);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    run(20);
    n_checks++;
    if (pulse_count !== 1 || last_cycle !== 7 || last_dir !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_repress: got %0d pulses cycle %0d dir %b expected 1 pulse cycle 7 dir 0010", pulse_count, last_cycle, last_dir);
    end
    btn_e = 1'b0;
    run(12);
  endtask

  task automatic test_saturation();
    do_reset();
    clear_mon();
    for (int i = 0; i < 300; i++) begin
      btn_e = 1'b1; run(8);
      btn_e = 1'b0; run(7);
      if (i == 254) begin
        n_checks++;
        if (moves !== 8'd255) begin
          n_fail++;
          $display("FAIL sat_reach: got %0d expected 255", moves);
        end
      end
    end
    n_checks++;
    if (moves !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_hold: got %0d expected 255", moves);
    end
    n_checks++;
    if (pulse_count !== 300) begin
      n_fail++;
      $display("FAIL sat_pulses: got %0d expected 300", pulse_count);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    game_over = 1'b0;
    {btn_n, btn_s, btn_e, btn_w} = 4'd0;
    clear_mon();
    test_reset();
    test_clean_press();
    test_bounce();
    test_chord();
    test_sequence();
    test_lock();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
